// File: rtl/threadbrain_pkg.sv
// Shared definitions for the threadbrain core array: the FORK opcode and the
// layout of a per-core start context {valid, ptr, pc}.
package threadbrain_pkg;

    localparam logic [3:0] FORK_OPCODE = 4'h7;

    // pc occupies the low 16 bits (zero-extended), ptr sits above it, valid on top
    localparam int CXT_PC_W    = 16;
    localparam int CXT_PC_LSB  = 0;
    localparam int CXT_PTR_LSB = CXT_PC_W;

    function automatic int cxt_valid_bit(input int ptrw);
        return CXT_PC_W + ptrw;
    endfunction

    function automatic int cxt_width(input int ptrw);
        return 1 + ptrw + CXT_PC_W;
    endfunction

endpackage

// File: rtl/fork_if.sv
// Fork request bus between the running cores and the fork scheduler.
interface fork_if #(
    parameter int NCORES = 4,
    parameter int PTRW   = 16,
    parameter int PCW    = 12
);
    // Handshake: core i raises fork_req[i] with ptr/pc slice i stable and holds it;
    // fork_ack[i] is combinational and the request is taken at the edge where
    // fork_req[i] && fork_ack[i]. At most one ack bit is high per cycle.
    logic [NCORES-1:0]      fork_req;
    logic [NCORES*PTRW-1:0] fork_ptr;
    logic [NCORES*PCW-1:0]  fork_pc;
    logic [NCORES-1:0]      fork_ack;

    modport master (output fork_req, output fork_ptr, output fork_pc, input fork_ack);
    modport slave  (input fork_req, input fork_ptr, input fork_pc, output fork_ack);

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: search starts at ptr and wraps, grant is one-hot.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    always_comb begin
        int idx;
        logic [IW-1:0] sel;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            sel = IW'(idx);
            if (!grant_valid && req[sel]) begin
                grant_valid = 1'b1;
                grant_idx   = sel;
                grant[sel]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fork_sched.sv
// Fork scheduler: arbitrates fork requests into a pending queue and dispatches
// each queued fork onto the lowest-index idle core; halting cores are reclaimed.
module fork_sched
    import threadbrain_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int PTRW   = 16,
    parameter int PCW    = 12,
    parameter int QDEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    fork_if.slave                            fork_bus,
    input  logic [NCORES-1:0]                core_halt,
    output logic [NCORES-1:0]                core_ens,
    output logic [NCORES-1:0]                launch,
    output logic [NCORES*cxt_width(PTRW)-1:0] fork_cxt_out,
    output logic [$clog2(QDEPTH+1)-1:0]      q_count,
    output logic                             all_idle
);

    localparam int CXTW = cxt_width(PTRW);
    localparam int VB   = cxt_valid_bit(PTRW);
    localparam int IW   = $clog2(NCORES);
    localparam int AW   = $clog2(QDEPTH);
    localparam int CW   = $clog2(QDEPTH+1);

    typedef struct packed {
        logic [PTRW-1:0] ptr;
        logic [PCW-1:0]  pc;
    } entry_t;

    entry_t            mem_q [QDEPTH];
    entry_t            mem_d [QDEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [NCORES-1:0] ens_q, ens_d, launch_q, launch_d;
    logic [CXTW-1:0]   cxt_q [NCORES];
    logic [CXTW-1:0]   cxt_d [NCORES];

    logic [NCORES-1:0] grant, idle, free_oh, halt_eff;
    logic [IW-1:0]     grant_idx;
    logic              grant_valid, full, accept, dispatch;
    entry_t            push_e, head_e;

    rr_arbiter #(.N(NCORES), .IW(IW)) u_arb (
        .req         (fork_bus.fork_req),
        .ptr         (rr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign full     = (cnt_q == CW'(QDEPTH));
    assign accept   = grant_valid && !full && !rst;
    assign idle     = ~ens_q;
    assign free_oh  = idle & (~idle + NCORES'(1));
    assign dispatch = (cnt_q != '0) && (|idle);
    assign halt_eff = core_halt & ens_q;
    assign head_e   = mem_q[rd_q];

    always_comb begin
        push_e.ptr = fork_bus.fork_ptr[int'(grant_idx)*PTRW +: PTRW];
        push_e.pc  = fork_bus.fork_pc[int'(grant_idx)*PCW +: PCW];
        fork_bus.fork_ack = accept ? grant : '0;
    end

    always_comb begin
        mem_d = mem_q;
        if (accept) begin
            mem_d[wr_q] = push_e;
        end
        wr_d  = wr_q + AW'(accept);
        rd_d  = rd_q + AW'(dispatch);
        cnt_d = cnt_q + CW'(accept) - CW'(dispatch);
        rr_d  = rr_q;
        if (accept) begin
            rr_d = (grant_idx == IW'(NCORES-1)) ? '0 : grant_idx + IW'(1);
        end
        // The dispatch target is chosen from registered enables, so a core halting
        // this cycle is not reused until the next edge.
        launch_d = dispatch ? free_oh : '0;
        ens_d    = (ens_q & ~halt_eff) | launch_d;
        for (int i = 0; i < NCORES; i++) begin
            cxt_d[i] = cxt_q[i];
            if (halt_eff[i]) begin
                cxt_d[i][VB] = 1'b0;
            end
            if (launch_d[i]) begin
                cxt_d[i] = {1'b1, head_e.ptr, CXT_PC_W'(head_e.pc)};
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            rr_q     <= '0;
            ens_q    <= NCORES'(1);
            launch_q <= '0;
            for (int i = 0; i < NCORES; i++) begin
                cxt_q[i] <= (i == 0) ? (CXTW'(1) << VB) : '0;
            end
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            ens_q    <= ens_d;
            launch_q <= launch_d;
            for (int i = 0; i < NCORES; i++) begin
                cxt_q[i] <= cxt_d[i];
            end
        end
    end

    always_comb begin
        fork_cxt_out = '0;
        for (int i = 0; i < NCORES; i++) begin
            fork_cxt_out[i*CXTW +: CXTW] = cxt_q[i];
        end
    end

    assign core_ens = ens_q;
    assign launch   = launch_q;
    assign q_count  = cnt_q;
    assign all_idle = (ens_q == '0) && (cnt_q == '0);

endmodule

// File: tb/tb_fork_sched.sv
// Directed table-driven bench for fork_sched: single fork, rotation, full queue,
// halt reuse, disabled-core halts, all-idle and mid-run reset.
module tb_fork_sched;
    import threadbrain_pkg::*;

    localparam int NC   = 4;
    localparam int PTRW = 16;
    localparam int PCW  = 12;
    localparam int QD   = 4;
    localparam int CXTW = 1 + PTRW + 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fork_if #(.NCORES(NC), .PTRW(PTRW), .PCW(PCW)) bus ();

    logic [NC-1:0]      core_halt, core_ens, launch;
    logic [NC*CXTW-1:0] fork_cxt_out;
    logic [2:0]         q_count;
    logic               all_idle;

    fork_sched #(.NCORES(NC), .PTRW(PTRW), .PCW(PCW), .QDEPTH(QD)) dut (
        .clk          (clk),
        .rst          (rst),
        .fork_bus     (bus),
        .core_halt    (core_halt),
        .core_ens     (core_ens),
        .launch       (launch),
        .fork_cxt_out (fork_cxt_out),
        .q_count      (q_count),
        .all_idle     (all_idle)
    );

    typedef struct {
        logic          rst;
        logic [NC-1:0] req;
        logic [NC-1:0] halt;
        logic [NC-1:0] ack;
        logic [NC-1:0] ens;
        logic [NC-1:0] launch;
        logic [2:0]    cnt;
        logic          idle;
        int            cidx;
        logic [CXTW-1:0] cxt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [PTRW-1:0] core_ptr(input int c);
        return PTRW'(16 * (c + 1));
    endfunction

    function automatic logic [PCW-1:0] core_pc(input int c);
        return PCW'(12'h123 + 12'h111 * c);
    endfunction

    // Context each core's fork would produce: {valid, ptr, 4'h0, pc}
    function automatic logic [CXTW-1:0] cx(input logic v, input int c);
        return {v, core_ptr(c), 4'h0, core_pc(c)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic [NC-1:0] req, input logic [NC-1:0] halt,
                        input logic [NC-1:0] ack, input logic [NC-1:0] ens,
                        input logic [NC-1:0] lch, input logic [2:0] cnt, input logic idle,
                        input int cidx, input logic [CXTW-1:0] cxt);
        vec_t v;
        v.rst = r; v.req = req; v.halt = halt; v.ack = ack; v.ens = ens;
        v.launch = lch; v.cnt = cnt; v.idle = idle; v.cidx = cidx; v.cxt = cxt;
        vecs.push_back(v);
    endtask

    function automatic logic [CXTW-1:0] slice(input int i);
        return fork_cxt_out[i*CXTW +: CXTW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        core_halt = '0;
        bus.fork_req = '0;
        for (int i = 0; i < NC; i++) begin
            bus.fork_ptr[i*PTRW +: PTRW] = core_ptr(i);
            bus.fork_pc[i*PCW +: PCW]    = core_pc(i);
        end

        //   rst req      halt     ack      ens      launch   cnt idle cidx cxt
        addv(0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1, 0, -1, '0);
        addv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0010, 0, 0, 1, cx(1, 0));
        addv(0, 4'b0010, 4'b0000, 4'b0010, 4'b0011, 4'b0000, 1, 0, -1, '0);
        addv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b0100, 0, 0, 2, cx(1, 1));
        // three simultaneous requesters, rotation starts at core 2 and wraps
        addv(0, 4'b0111, 4'b0000, 4'b0100, 4'b0111, 4'b0000, 1, 0, -1, '0);
        addv(0, 4'b0011, 4'b0000, 4'b0001, 4'b1111, 4'b1000, 1, 0, 3, cx(1, 2));
        addv(0, 4'b0010, 4'b0000, 4'b0010, 4'b1111, 4'b0000, 2, 0, -1, '0);
        // fill the queue, fifth request is held
        addv(0, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 4'b0000, 3, 0, -1, '0);
        addv(0, 4'b1000, 4'b0000, 4'b1000, 4'b1111, 4'b0000, 4, 0, -1, '0);
        addv(0, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4, 0, -1, '0);
        addv(0, 4'b0001, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 4, 0, 2, cx(0, 1));
        addv(0, 4'b0001, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 3, 0, 2, cx(1, 0));
        addv(0, 4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b0000, 4, 0, -1, '0);
        // halt reuse with 1-cycle turnaround
        addv(0, 4'b0000, 4'b0100, 4'b0000, 4'b1011, 4'b0000, 4, 0, 2, cx(0, 0));
        addv(0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 3, 0, 2, cx(1, 1));
        addv(0, 4'b0000, 4'b1010, 4'b0000, 4'b0101, 4'b0000, 3, 0, 3, cx(0, 2));
        addv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b0010, 2, 0, 1, cx(1, 2));
        addv(0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1000, 1, 0, 3, cx(1, 3));
        // halts on disabled cores are ignored
        addv(0, 4'b0000, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 1, 0, 0, '0);
        addv(0, 4'b0000, 4'b0001, 4'b0000, 4'b1111, 4'b0001, 0, 0, 0, cx(1, 0));
        addv(0, 4'b0000, 4'b1000, 4'b0000, 4'b0111, 4'b0000, 0, 0, 3, cx(0, 3));
        addv(0, 4'b0000, 4'b1000, 4'b0000, 4'b0111, 4'b0000, 0, 0, 3, cx(0, 3));
        addv(0, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 0, 1, -1, '0);
        // restart from all-idle, build up three queued forks
        addv(0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0, -1, '0);
        addv(0, 4'b0010, 4'b0000, 4'b0010, 4'b0001, 4'b0001, 1, 0, 0, cx(1, 0));
        addv(0, 4'b0100, 4'b0000, 4'b0100, 4'b0011, 4'b0010, 1, 0, 1, cx(1, 1));
        addv(0, 4'b1000, 4'b0000, 4'b1000, 4'b0111, 4'b0100, 1, 0, 2, cx(1, 2));
        addv(0, 4'b0001, 4'b0000, 4'b0001, 4'b1111, 4'b1000, 1, 0, 3, cx(1, 3));
        addv(0, 4'b0010, 4'b0000, 4'b0010, 4'b1111, 4'b0000, 2, 0, -1, '0);
        addv(0, 4'b0100, 4'b0000, 4'b0100, 4'b1111, 4'b0000, 3, 0, -1, '0);
        // mid-run reset discards the queue
        addv(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0, {1'b1, 32'h0});
        addv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 1, '0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ens", 64'(core_ens), 64'(4'b0001));
        check("rst_launch", 64'(launch), 64'(4'b0000));
        check("rst_qcount", 64'(q_count), 64'(0));
        check("rst_all_idle", 64'(all_idle), 64'(0));
        check("rst_cxt0", 64'(slice(0)), 64'({1'b1, 32'h0}));
        for (int i = 1; i < NC; i++) begin
            check($sformatf("rst_cxt%0d", i), 64'(slice(i)), 64'(0));
        end

        for (int k = 0; k < vecs.size(); k++) begin
            rst          = vecs[k].rst;
            bus.fork_req = vecs[k].req;
            core_halt    = vecs[k].halt;
            #1;
            check($sformatf("v%0d_ack", k), 64'(bus.fork_ack), 64'(vecs[k].ack));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ens", k), 64'(core_ens), 64'(vecs[k].ens));
            check($sformatf("v%0d_launch", k), 64'(launch), 64'(vecs[k].launch));
            check($sformatf("v%0d_qcount", k), 64'(q_count), 64'(vecs[k].cnt));
            check($sformatf("v%0d_all_idle", k), 64'(all_idle), 64'(vecs[k].idle));
            if (vecs[k].cidx >= 0) begin
                check($sformatf("v%0d_cxt%0d", k, vecs[k].cidx), 64'(slice(vecs[k].cidx)),
                      64'(vecs[k].cxt));
            end
        end

        // after the mid-run reset every non-boot context is cleared and stays quiet
        for (int i = 1; i < NC; i++) begin
            check($sformatf("post_rst_cxt%0d", i), 64'(slice(i)), 64'(0));
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post_rst_launch", 64'(launch), 64'(0));
            check("post_rst_ens", 64'(core_ens), 64'(4'b0001));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
